// File: rtl/nios2_cpu_oci_dct_packer.sv
// Trace-atom packer for the Nios II OCI debug path.
// Shifts 2-bit trace atoms into a 15-atom buffer and hands packed frames
// to the trace FIFO through a single-entry valid/ready output register.
// The live buffer and its occupancy are exported for the OCI sim monitor.
module nios2_cpu_oci_dct_packer #(
    parameter int ATOM_W    = 2,
    parameter int DCT_DEPTH = 15
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        trace_enable,
    input  logic                        atom_valid,
    input  logic [ATOM_W-1:0]           atom,
    input  logic                        flush,
    output logic                        frame_valid,
    output logic [ATOM_W*DCT_DEPTH-1:0] frame_data,
    output logic [3:0]                  frame_count,
    input  logic                        frame_ready,
    output logic [ATOM_W*DCT_DEPTH-1:0] dct_buffer,
    output logic [3:0]                  dct_count,
    output logic                        overflow,
    input  logic                        overflow_clr
);

    localparam int BUF_W = ATOM_W * DCT_DEPTH;
    localparam logic [3:0] DEPTH_C = 4'(DCT_DEPTH);

    logic [BUF_W-1:0] r_buf;
    logic [3:0]       r_count;
    logic             r_frame_valid;
    logic [BUF_W-1:0] r_frame_data;
    logic [3:0]       r_frame_count;
    logic             r_flush_pend;
    logic             r_overflow;

    logic [BUF_W-1:0] w_next_buf;
    logic [3:0]       w_next_count;
    logic             w_atom_req;
    logic             w_full;
    logic             w_accept;
    logic             w_drop;
    logic             w_out_free;
    logic             w_has_atoms;
    logic             w_trigger;
    logic             w_emit;

    assign w_atom_req = atom_valid & trace_enable;
    assign w_full     = (r_count == DEPTH_C);
    assign w_accept   = w_atom_req & ~w_full;
    assign w_drop     = w_atom_req & w_full;

    // Post-accept view of the buffer: the emit decision and the emitted
    // frame both include an atom arriving in the same cycle.
    always_comb begin
        w_next_buf   = r_buf;
        w_next_count = r_count;
        if (w_accept) begin
            w_next_buf   = {r_buf[BUF_W-ATOM_W-1:0], atom};
            w_next_count = r_count + 4'd1;
        end
    end

    // Output slot can take a new frame if empty or being drained this cycle.
    assign w_out_free  = ~r_frame_valid | frame_ready;
    assign w_has_atoms = (w_next_count != 4'd0);
    assign w_trigger   = (w_next_count == DEPTH_C) |
                         ((flush | r_flush_pend) & w_has_atoms);
    assign w_emit      = w_trigger & w_out_free;

    // Packing buffer: cleared when its contents move to the output slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf   <= '0;
            r_count <= '0;
        end else if (w_emit) begin
            r_buf   <= '0;
            r_count <= '0;
        end else begin
            r_buf   <= w_next_buf;
            r_count <= w_next_count;
        end
    end

    // Output register: reload has priority so drain and refill share a cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_valid <= 1'b0;
            r_frame_data  <= '0;
            r_frame_count <= '0;
        end else if (w_emit) begin
            r_frame_valid <= 1'b1;
            r_frame_data  <= w_next_buf;
            r_frame_count <= w_next_count;
        end else if (frame_ready) begin
            r_frame_valid <= 1'b0;
        end
    end

    // Remember a flush that could not be honoured while the output was busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flush_pend <= 1'b0;
        end else if (w_emit) begin
            r_flush_pend <= 1'b0;
        end else if (flush & w_has_atoms) begin
            r_flush_pend <= 1'b1;
        end
    end

    // Sticky overflow: a drop beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign frame_valid = r_frame_valid;
    assign frame_data  = r_frame_data;
    assign frame_count = r_frame_count;
    assign dct_buffer  = r_buf;
    assign dct_count   = r_count;
    assign overflow    = r_overflow;

endmodule
